// File: rtl/cvxif_copro_responder.sv
// Single-issue coprocessor responder: ADD/XOR complete at issue, MUL runs a
// shift-add loop; each result waits for its commit and is then offered once.
//
// state       | meaning
// IDLE        | ready for a new instruction
// EXEC        | shift-add multiply, one multiplier bit per cycle
// WAIT_COMMIT | result computed, waiting for the commit of the captured id
// RESP        | result offered until result_ready_i
module cvxif_copro_responder #(
    parameter int XLEN     = 64,
    parameter int ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [4:0]          result_rd_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic                result_we_o
);
    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT_COMMIT, RESP} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] id_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     data_q;
    logic [XLEN-1:0]     mcand_q;
    logic [XLEN-1:0]     mplr_q;
    logic [CW-1:0]       cnt_q;
    logic                committed_q;

    logic       handshake;
    logic       accepted;
    logic [2:0] funct3;
    logic       commit_hs;
    logic       kill_hs;
    logic       commit_match;
    logic       kill_match;
    logic       unused_instr_bits;

    assign funct3            = issue_instr_i[14:12];
    assign unused_instr_bits = ^issue_instr_i[31:15];

    always_comb begin
        issue_ready_o     = (state == IDLE) && !rst_i;
        handshake         = issue_valid_i && issue_ready_o;
        accepted          = handshake && (issue_instr_i[6:0] == 7'h7B)
                            && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        issue_accept_o    = accepted;
        issue_writeback_o = accepted;
        // Commit notices are matched against the offered id during the handshake
        // and against the captured id afterwards.
        commit_hs    = commit_valid_i && !commit_kill_i && (commit_id_i == issue_id_i);
        kill_hs      = commit_valid_i &&  commit_kill_i && (commit_id_i == issue_id_i);
        commit_match = commit_valid_i && !commit_kill_i && (commit_id_i == id_q);
        kill_match   = commit_valid_i &&  commit_kill_i && (commit_id_i == id_q);
    end

    assign result_valid_o = (state == RESP);
    assign result_we_o    = (state == RESP) && (rd_q != 5'd0);
    assign result_id_o    = id_q;
    assign result_rd_o    = rd_q;
    assign result_data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            id_q        <= '0;
            rd_q        <= '0;
            data_q      <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            cnt_q       <= '0;
            committed_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accepted && !kill_hs) begin
                        id_q        <= issue_id_i;
                        rd_q        <= issue_instr_i[11:7];
                        committed_q <= commit_hs;
                        case (funct3)
                            3'b000: begin
                                data_q <= issue_rs1_i + issue_rs2_i;
                                state  <= commit_hs ? RESP : WAIT_COMMIT;
                            end
                            3'b001: begin
                                data_q <= issue_rs1_i ^ issue_rs2_i;
                                state  <= commit_hs ? RESP : WAIT_COMMIT;
                            end
                            default: begin
                                data_q  <= '0;
                                mcand_q <= issue_rs1_i;
                                mplr_q  <= issue_rs2_i;
                                cnt_q   <= CW'(XLEN - 1);
                                state   <= EXEC;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (kill_match) begin
                        state <= IDLE;
                    end else begin
                        if (mplr_q[0]) data_q <= data_q + mcand_q;
                        mcand_q <= mcand_q << 1;
                        mplr_q  <= mplr_q >> 1;
                        if (commit_match) committed_q <= 1'b1;
                        if (cnt_q == '0)
                            state <= (committed_q || commit_match) ? RESP : WAIT_COMMIT;
                        else
                            cnt_q <= cnt_q - 1'b1;
                    end
                end
                WAIT_COMMIT: begin
                    if (kill_match) begin
                        state <= IDLE;
                    end else if (commit_match || committed_q) begin
                        committed_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (result_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
